// File: rtl/rx_fifo_frame_drain_pkg.sv
// Shared definitions for the RX FIFO read-side frame sequencer.
// - state_e : sequencer states (2-bit encoding)
// - eop_bit / err_bit : flag bit positions in a FIFO word for a given payload width
package rx_fifo_frame_drain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DROP  = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  function automatic int unsigned eop_bit(input int unsigned data_width);
    return data_width;
  endfunction

  function automatic int unsigned err_bit(input int unsigned data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/rx_fifo_frame_drain_sat_counter.sv
// Saturating up-counter used for the frame and truncation statistics.
// Ports:
//   iClk    - clock
//   inReset - synchronous active-low reset (clears the count)
//   iInc    - increment by one, holding at all-ones
//   iClr    - synchronous clear (takes priority over iInc)
//   ovCnt   - current count
module sat_counter #(
  parameter int unsigned pWidth = 16
) (
  input  logic              iClk,
  input  logic              inReset,
  input  logic              iInc,
  input  logic              iClr,
  output logic [pWidth-1:0] ovCnt
);

  logic [pWidth-1:0] cnt_q;
  logic [pWidth-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (iClr) begin
      cnt_d = '0;
    end else if (iInc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge iClk) begin
    if (!inReset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ovCnt = cnt_q;

endmodule

// File: rtl/rx_fifo_frame_drain.sv
// Read-side frame sequencer for the 10G RX async FIFO (read-clock domain).
// Pops first-word-fall-through FIFO words, forwards frames downstream with a
// valid/ready handshake, truncates frames longer than pMaxWords (discarding the
// remainder up to EOP), supports a level-sensitive flush and keeps saturating
// frame / truncation statistics.
// Ports:
//   iClk, inReset        - clock, synchronous active-low reset
//   ivFifoData           - FIFO head word {ERR, EOP, payload}; valid when !iFifoEmpty
//   iFifoEmpty           - FIFO empty flag
//   oFifoREn             - pop FIFO head this cycle (combinational)
//   iEnable              - allows a new frame to start (looked at only in IDLE)
//   iFlush               - discard FIFO contents while high
//   ovData/oValid/oEop/oErr/iReady - downstream word handshake (combinational)
//   ovFrameLen/oFrameDone - registered length of the last completed frame + pulse
//   ovFrameCnt/ovTruncCnt - saturating statistics
//   oBusy                - sequencer not idle
module rx_fifo_frame_drain
  import rx_fifo_frame_drain_pkg::*;
#(
  parameter int unsigned pDataWidth = 64,
  parameter int unsigned pWordWidth = 66,
  parameter int unsigned pLenWidth  = 11,
  parameter int unsigned pMaxWords  = 1200,
  parameter int unsigned pStatWidth = 16
) (
  input  logic                  iClk,
  input  logic                  inReset,
  input  logic [pWordWidth-1:0] ivFifoData,
  input  logic                  iFifoEmpty,
  output logic                  oFifoREn,
  input  logic                  iEnable,
  input  logic                  iFlush,
  output logic [pDataWidth-1:0] ovData,
  output logic                  oValid,
  output logic                  oEop,
  output logic                  oErr,
  input  logic                  iReady,
  output logic [pLenWidth-1:0]  ovFrameLen,
  output logic                  oFrameDone,
  output logic [pStatWidth-1:0] ovFrameCnt,
  output logic [pStatWidth-1:0] ovTruncCnt,
  output logic                  oBusy
);

  localparam int unsigned EopBit = eop_bit(pDataWidth);
  localparam int unsigned ErrBit = err_bit(pDataWidth);
  localparam logic [pLenWidth-1:0] LastCnt = pLenWidth'(pMaxWords - 1);
  localparam logic [pLenWidth-1:0] MaxLen  = pLenWidth'(pMaxWords);

  state_e                 state_q, state_d;
  logic [pLenWidth-1:0]   count_q, count_d;
  logic [pLenWidth-1:0]   frame_len_q, frame_len_d;
  logic                   frame_done_q, frame_done_d;
  logic                   inc_frame;
  logic                   inc_trunc;

  logic                   head_eop;
  logic                   head_err;
  logic                   trunc;
  logic                   valid;
  logic                   ren;

  assign head_eop = ivFifoData[EopBit];
  assign head_err = ivFifoData[ErrBit];

  // The word that would reach pMaxWords without carrying EOP is turned into a
  // forced EOP+ERR word; only meaningful while oValid is high.
  assign trunc = (state_q == ST_XFER) && !head_eop && (count_q == LastCnt);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    frame_len_d  = frame_len_q;
    frame_done_d = 1'b0;
    inc_frame    = 1'b0;
    inc_trunc    = 1'b0;
    valid        = 1'b0;
    ren          = 1'b0;

    if (iFlush) begin
      // Flush overrides every state: nothing is offered downstream and the
      // head is discarded, including on the cycle flush is first seen.
      state_d = ST_FLUSH;
      count_d = '0;
      ren     = !iFifoEmpty;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (iEnable && !iFifoEmpty) begin
            state_d = ST_XFER;
          end
        end

        ST_XFER: begin
          valid = !iFifoEmpty;
          ren   = valid && iReady;
          if (ren) begin
            if (head_eop) begin
              state_d      = ST_IDLE;
              frame_len_d  = count_q + 1'b1;
              frame_done_d = 1'b1;
              inc_frame    = 1'b1;
              count_d      = '0;
            end else if (count_q == LastCnt) begin
              state_d      = ST_DROP;
              frame_len_d  = MaxLen;
              frame_done_d = 1'b1;
              inc_frame    = 1'b1;
              inc_trunc    = 1'b1;
              count_d      = '0;
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end

        ST_DROP: begin
          ren = !iFifoEmpty;
          if (ren && head_eop) begin
            state_d = ST_IDLE;
          end
        end

        ST_FLUSH: begin
          ren = !iFifoEmpty;
          if (iFifoEmpty) begin
            state_d = ST_IDLE;
            count_d = '0;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (!inReset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      frame_len_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      frame_len_q  <= frame_len_d;
      frame_done_q <= frame_done_d;
    end
  end

  sat_counter #(
    .pWidth (pStatWidth)
  ) u_frame_cnt (
    .iClk    (iClk),
    .inReset (inReset),
    .iInc    (inc_frame),
    .iClr    (1'b0),
    .ovCnt   (ovFrameCnt)
  );

  sat_counter #(
    .pWidth (pStatWidth)
  ) u_trunc_cnt (
    .iClk    (iClk),
    .inReset (inReset),
    .iInc    (inc_trunc),
    .iClr    (1'b0),
    .ovCnt   (ovTruncCnt)
  );

  assign oFifoREn   = ren;
  assign oValid     = valid;
  assign ovData     = ivFifoData[pDataWidth-1:0];
  assign oEop       = head_eop | trunc;
  assign oErr       = head_err | trunc;
  assign ovFrameLen = frame_len_q;
  assign oFrameDone = frame_done_q;
  assign oBusy      = (state_q != ST_IDLE);

endmodule
